// File: rtl/alu_pkg.sv
// Shared definitions for the m_alu execute stage: opcode encoding, flag bit
// positions and the common Z/N flag builder.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_SHL  = 4'h4,
        OP_SHR  = 4'h5,
        OP_AND  = 4'h6,
        OP_OR   = 4'h7,
        OP_XOR  = 4'h8,
        OP_XNOR = 4'h9,
        OP_NAND = 4'hA,
        OP_NOR  = 4'hB,
        OP_ROL  = 4'hC,
        OP_ROR  = 4'hD,
        OP_GT   = 4'hE,
        OP_EQ   = 4'hF
    } alu_op_e;

    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    // Z and N always derive from the result; C and V come from the operation.
    function automatic logic [3:0] make_flags(input logic carry, input logic [7:0] res,
                                              input logic ovf);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_C] = carry;
        f[FLAG_Z] = (res == 8'h00);
        f[FLAG_N] = res[7];
        f[FLAG_V] = ovf;
        return f;
    endfunction

endpackage

// File: rtl/m_alu_core.sv
// Combinational datapath of the ALU: next result byte and next status flags
// from the operands and operation select.
module m_alu_core
    import alu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] sel,
    output logic [7:0] result,
    output logic [3:0] flags
);

    alu_op_e     op_s;
    logic [8:0]  sum_s;
    logic [8:0]  diff_s;
    logic [15:0] prod_s;
    logic [7:0]  quot_s;
    logic [2:0]  shamt_s;
    logic [8:0]  shl_s;
    logic [8:0]  shr_s;
    logic [7:0]  res_s;
    logic        carry_s;
    logic        ovf_s;

    assign op_s    = alu_op_e'(sel);
    assign shamt_s = b[2:0];
    assign sum_s   = {1'b0, a} + {1'b0, b};
    assign diff_s  = {1'b0, a} - {1'b0, b};
    assign prod_s  = {8'h00, a} * {8'h00, b};
    assign quot_s  = (b == 8'h00) ? 8'hFF : (a / b);

    // One spare bit on each shifter catches the last bit shifted out (0 when n=0).
    assign shl_s   = {1'b0, a} << shamt_s;
    assign shr_s   = {a, 1'b0} >> shamt_s;

    // Per-operation result, carry/borrow and signed overflow.
    always_comb begin
        res_s   = 8'h00;
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        case (op_s)
            OP_ADD: begin
                res_s   = sum_s[7:0];
                carry_s = sum_s[8];
                ovf_s   = (a[7] == b[7]) && (sum_s[7] != a[7]);
            end
            OP_SUB: begin
                res_s   = diff_s[7:0];
                carry_s = diff_s[8];
                ovf_s   = (a[7] != b[7]) && (diff_s[7] != a[7]);
            end
            OP_MUL: begin
                res_s   = prod_s[7:0];
                carry_s = (prod_s[15:8] != 8'h00);
            end
            OP_DIV: begin
                res_s   = quot_s;
                carry_s = (b == 8'h00);
            end
            OP_SHL: begin
                res_s   = shl_s[7:0];
                carry_s = shl_s[8];
            end
            OP_SHR: begin
                res_s   = shr_s[8:1];
                carry_s = shr_s[0];
            end
            OP_AND:  res_s = a & b;
            OP_OR:   res_s = a | b;
            OP_XOR:  res_s = a ^ b;
            OP_XNOR: res_s = ~(a ^ b);
            OP_NAND: res_s = ~(a & b);
            OP_NOR:  res_s = ~(a | b);
            OP_ROL: begin
                res_s   = {a[6:0], a[7]};
                carry_s = a[7];
            end
            OP_ROR: begin
                res_s   = {a[0], a[7:1]};
                carry_s = a[0];
            end
            OP_GT:   res_s = (a > b) ? 8'h01 : 8'h00;
            OP_EQ:   res_s = (a == b) ? 8'h01 : 8'h00;
            default: begin
                res_s   = 8'h00;
                carry_s = 1'b0;
                ovf_s   = 1'b0;
            end
        endcase
    end

    assign result = res_s;
    assign flags  = make_flags(carry_s, res_s, ovf_s);

endmodule

// File: rtl/m_alu.sv
// Registered 8-bit ALU execute stage: one-cycle latency, outputs cleared
// asynchronously while rst_n is low.
module m_alu
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [3:0] ALU_Sel,
    output logic [7:0] ALU_Out,
    output logic [3:0] Flag
);

    logic [7:0] result_s;
    logic [3:0] flags_s;
    logic [7:0] alu_out_r;
    logic [3:0] flag_r;

    m_alu_core u_core (
        .a      (A),
        .b      (B),
        .sel    (ALU_Sel),
        .result (result_s),
        .flags  (flags_s)
    );

    // Output registers: capture the core result every edge, clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out_r <= 8'h00;
            flag_r    <= 4'h0;
        end else begin
            alu_out_r <= result_s;
            flag_r    <= flags_s;
        end
    end

    assign ALU_Out = alu_out_r;
    assign Flag    = flag_r;

endmodule

// File: tb/tb_m_alu.sv
// Scoreboard bench for m_alu: directed test-plan vectors plus random traffic
// checked against an arithmetic reference model.
module tb_m_alu;

    logic       clk;
    logic       rst_n;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] ALU_Sel;
    logic [7:0] ALU_Out;
    logic [3:0] Flag;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [7:0] out;
        logic [3:0] flag;
        logic [3:0] sel;
    } exp_t;

    exp_t sb_q[$];

    m_alu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .ALU_Sel (ALU_Sel),
        .ALU_Out (ALU_Out),
        .Flag    (Flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] model(input logic [3:0] sel, input logic [7:0] a,
                                          input logic [7:0] b);
        int ia, ib, sa, sb, r, s, n;
        bit c, v;
        ia = a; ib = b;
        sa = (ia > 127) ? ia - 256 : ia;
        sb = (ib > 127) ? ib - 256 : ib;
        n = ib % 8;
        r = 0; c = 0; v = 0;
        case (sel)
            4'h0: begin r = ia + ib; c = (r > 255); r = r % 256;
                        s = sa + sb; v = (s > 127) || (s < -128); end
            4'h1: begin c = (ia < ib); r = (ia - ib + 256) % 256;
                        s = sa - sb; v = (s > 127) || (s < -128); end
            4'h2: begin r = ia * ib; c = (r > 255); r = r % 256; end
            4'h3: begin if (ib == 0) begin r = 255; c = 1; end else r = ia / ib; end
            4'h4: begin r = (ia * (1 << n)) % 256; c = (n > 0) ? ((ia >> (8 - n)) % 2 == 1) : 0; end
            4'h5: begin r = ia >> n; c = (n > 0) ? ((ia >> (n - 1)) % 2 == 1) : 0; end
            4'h6: r = ia & ib;
            4'h7: r = ia | ib;
            4'h8: r = ia ^ ib;
            4'h9: r = 255 - (ia ^ ib);
            4'hA: r = 255 - (ia & ib);
            4'hB: r = 255 - (ia | ib);
            4'hC: begin r = (ia * 2) % 256 + ia / 128; c = (ia >= 128); end
            4'hD: begin r = ia / 2 + (ia % 2) * 128; c = (ia % 2 == 1); end
            4'hE: r = (ia > ib) ? 1 : 0;
            4'hF: r = (ia == ib) ? 1 : 0;
            default: r = 0;
        endcase
        return {c, (r == 0), (r >= 128), v, 8'(r)};
    endfunction

    task automatic issue(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eo, input logic [3:0] ef);
        exp_t e;
        @(negedge clk);
        ALU_Sel = sel; A = a; B = b;
        e.out = eo; e.flag = ef; e.sel = sel;
        sb_q.push_back(e);
    endtask

    task automatic issue_rand();
        logic [3:0]  sel;
        logic [7:0]  a, b;
        logic [11:0] m;
        sel = 4'($urandom_range(0, 15));
        a = 8'($urandom_range(0, 255));
        b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
        m = model(sel, a, b);
        issue(sel, a, b, m[7:0], m[11:8]);
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if (ALU_Out !== 8'h00 || Flag !== 4'h0) begin
            n_bad++;
            $display("FAIL %s: out=%h flag=%b, required out=00 flag=0000", name, ALU_Out, Flag);
        end
    endtask

    // Monitor: every edge after reset retires one expectation, one cycle after issue.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (ALU_Out !== e.out || Flag !== e.flag) begin
                n_bad++;
                $display("FAIL op%h: out=%h flag=%b, required out=%h flag=%b",
                         e.sel, ALU_Out, Flag, e.out, e.flag);
            end
        end
    end

    initial begin
        int budget;
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; A = 8'h00; B = 8'h00; ALU_Sel = 4'h0;
        repeat (3) @(posedge clk);
        #2 check_zero("reset_state");
        @(negedge clk) rst_n = 1'b1;

        issue(4'h0, 8'h01, 8'h02, 8'h03, 4'b0000);
        issue(4'h0, 8'h7F, 8'h01, 8'h80, 4'b0011);
        issue(4'h1, 8'h71, 8'h06, 8'h6B, 4'b0000);
        issue(4'h1, 8'h01, 8'h02, 8'hFF, 4'b1010);
        issue(4'h2, 8'h01, 8'h02, 8'h02, 4'b0000);
        issue(4'h2, 8'h10, 8'h10, 8'h00, 4'b1100);
        issue(4'h3, 8'h01, 8'h04, 8'h00, 4'b0100);
        issue(4'h3, 8'h09, 8'h00, 8'hFF, 4'b1010);
        issue(4'h4, 8'h71, 8'h06, 8'h40, 4'b0000);
        issue(4'h5, 8'h01, 8'h02, 8'h00, 4'b0100);
        issue(4'hC, 8'h81, 8'h00, 8'h03, 4'b1000);
        issue(4'hD, 8'h01, 8'h00, 8'h80, 4'b1010);
        issue(4'h6, 8'h01, 8'h04, 8'h00, 4'b0100);
        issue(4'h7, 8'h71, 8'h06, 8'h77, 4'b0000);
        issue(4'h8, 8'h01, 8'h04, 8'h05, 4'b0000);
        issue(4'h9, 8'h71, 8'h06, 8'h88, 4'b0010);
        issue(4'hA, 8'h01, 8'h04, 8'hFF, 4'b0010);
        issue(4'hB, 8'h71, 8'h06, 8'h88, 4'b0010);
        issue(4'hE, 8'h02, 8'h01, 8'h01, 4'b0000);
        issue(4'hF, 8'h05, 8'h05, 8'h01, 4'b0000);
        issue(4'hF, 8'h01, 8'h02, 8'h00, 4'b0100);

        for (int i = 0; i < 300; i++) issue_rand();

        // Reset mid-operation: outputs must clear without a clock edge.
        issue(4'h0, 8'h10, 8'h20, 8'h30, 4'b0000);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_zero("async_reset");
        A = 8'hFF; B = 8'h01; ALU_Sel = 4'h0;
        @(posedge clk);
        #2 check_zero("reset_hold");
        @(negedge clk) rst_n = 1'b1;
        issue(4'h0, 8'h01, 8'h02, 8'h03, 4'b0000);
        for (int i = 0; i < 20; i++) issue_rand();

        budget = 0;
        while (sb_q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        #2;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d pending, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
